dbg_uart_loader: RTL

//  Host-side driver of the SoC debug memory port: turns a byte stream from the UART receiver into dbg_adr/dbg_do/dbg_wren/dbg_mem_op

---
 rtl/dbg_uart_loader.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/dbg_uart_loader.sv
// Host-side debug memory loader: parses W/R/H/G frames from the UART byte
// stream, drives the debug memory port and the CPU reset, and replies over tx.
module dbg_uart_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned WR_CYCLES      = 2,
  parameter int unsigned RD_LAT         = 1,
  parameter bit          BOOT_HALTED    = 1'b1
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        dbg_mem_op,
  output logic [3:0]  dbg_wren,
  output logic [31:0] dbg_adr,
  output logic [31:0] dbg_do,
  input  logic [31:0] dbg_di,
  output logic        cpu_n_reset
);

  localparam int unsigned CYC_MAX = (WR_CYCLES > RD_LAT) ? WR_CYCLES : RD_LAT;
  localparam int unsigned CYC_W   = $clog2(CYC_MAX + 1);
  localparam int unsigned TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic        CPU_RST_INIT = (BOOT_HALTED == 1'b0);

  localparam logic [7:0] CH_W = 8'h57;
  localparam logic [7:0] CH_R = 8'h52;
  localparam logic [7:0] CH_H = 8'h48;
  localparam logic [7:0] CH_G = 8'h47;
  localparam logic [7:0] CH_K = 8'h4B;
  localparam logic [7:0] CH_E = 8'h45;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_MEM_WR, S_MEM_RD, S_TX} state_e;
  typedef enum logic [1:0] {TX_WAIT_IDLE, TX_PULSE, TX_WAIT_RISE, TX_WAIT_FALL} txph_e;

  state_e             state_q, state_d;
  txph_e              txph_q, txph_d;
  logic [7:0]         cmd_q, cmd_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        data_q, data_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic [31:0]        rbuf_q, rbuf_d;
  logic [2:0]         rleft_q, rleft_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic [31:0]        adr_q, adr_d;
  logic [31:0]        do_q, do_d;
  logic               cpu_q, cpu_d;
  logic               reply_en;
  logic [7:0]         reply_byte;

  // State and datapath registers.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q   <= S_IDLE;
      txph_q    <= TX_WAIT_IDLE;
      cmd_q     <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      tmo_q     <= '0;
      cyc_q     <= '0;
      rbuf_q    <= '0;
      rleft_q   <= '0;
      tx_data_q <= '0;
      adr_q     <= '0;
      do_q      <= '0;
      cpu_q     <= CPU_RST_INIT;
    end else begin
      state_q   <= state_d;
      txph_q    <= txph_d;
      cmd_q     <= cmd_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      tmo_q     <= tmo_d;
      cyc_q     <= cyc_d;
      rbuf_q    <= rbuf_d;
      rleft_q   <= rleft_d;
      tx_data_q <= tx_data_d;
      adr_q     <= adr_d;
      do_q      <= do_d;
      cpu_q     <= cpu_d;
    end
  end

  // Frame parser, bus sequencing and reply transmission.
  always_comb begin
    state_d    = state_q;
    txph_d     = txph_q;
    cmd_d      = cmd_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    tmo_d      = tmo_q;
    cyc_d      = cyc_q;
    rbuf_d     = rbuf_q;
    rleft_d    = rleft_q;
    tx_data_d  = tx_data_q;
    adr_d      = adr_q;
    do_d       = do_q;
    cpu_d      = cpu_q;
    reply_en   = 1'b0;
    reply_byte = CH_K;

    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            CH_W, CH_R: begin
              cmd_d   = rx_data;
              cnt_d   = '0;
              tmo_d   = '0;
              state_d = S_ADDR;
            end
            CH_H: begin
              cpu_d    = 1'b0;
              reply_en = 1'b1;
            end
            CH_G: begin
              cpu_d    = 1'b1;
              reply_en = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_ADDR, S_DATA: begin
        if (rx_valid) begin
          tmo_d = '0;
          cnt_d = cnt_q + 2'd1;
          if (state_q == S_ADDR) addr_d[{cnt_q, 3'b000} +: 8] = rx_data;
          else                   data_d[{cnt_q, 3'b000} +: 8] = rx_data;
          if (cnt_q == 2'd3) begin
            if (state_q == S_ADDR && cmd_q == CH_W) begin
              state_d = S_DATA;
            end else if (cpu_q) begin
              reply_en   = 1'b1;
              reply_byte = CH_E;
            end else begin
              adr_d   = addr_d;
              cyc_d   = '0;
              if (cmd_q == CH_W) begin
                do_d    = data_d;
                state_d = S_MEM_WR;
              end else begin
                state_d = S_MEM_RD;
              end
            end
          end
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_MEM_WR: begin
        if (cyc_q == CYC_W'(WR_CYCLES - 1)) reply_en = 1'b1;
        else                                cyc_d    = cyc_q + 1'b1;
      end
      S_MEM_RD: begin
        if (cyc_q == CYC_W'(RD_LAT)) begin
          rbuf_d  = dbg_di;
          rleft_d = 3'd4;
          txph_d  = TX_WAIT_IDLE;
          state_d = S_TX;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_TX: begin
        case (txph_q)
          TX_WAIT_IDLE: if (!tx_busy) begin
            tx_data_d = rbuf_q[7:0];
            txph_d    = TX_PULSE;
          end
          TX_PULSE:     txph_d = TX_WAIT_RISE;
          TX_WAIT_RISE: if (tx_busy) txph_d = TX_WAIT_FALL;
          TX_WAIT_FALL: if (!tx_busy) begin
            rbuf_d  = {8'h00, rbuf_q[31:8]};
            rleft_d = rleft_q - 3'd1;
            txph_d  = TX_WAIT_IDLE;
            if (rleft_q == 3'd1) state_d = S_IDLE;
          end
          default: txph_d = TX_WAIT_IDLE;
        endcase
      end
      default: state_d = S_IDLE;
    endcase

    if (reply_en) begin
      rbuf_d  = {24'h0, reply_byte};
      rleft_d = 3'd1;
      txph_d  = TX_WAIT_IDLE;
      state_d = S_TX;
    end
  end

  // Bus and transmit strobes decoded from the current state.
  always_comb begin
    dbg_mem_op = (state_q == S_MEM_WR) || (state_q == S_MEM_RD);
    dbg_wren   = (state_q == S_MEM_WR) ? 4'hF : 4'h0;
    tx_start   = (state_q == S_TX) && (txph_q == TX_PULSE);
  end

  assign tx_data     = tx_data_q;
  assign dbg_adr     = adr_q;
  assign dbg_do      = do_q;
  assign cpu_n_reset = cpu_q;

endmodule
